// File: rtl/mem_pkg.sv
// Shared opcodes, FSM state encoding and widths for the memory initiator.
package mem_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_COPY  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WR    = 3'd2,
        S_CP_RD = 3'd3,
        S_CP_WR = 3'd4,
        S_FIN   = 3'd5
    } state_e;

endpackage

// File: rtl/mem_xfer_counter.sv
// Block-copy offset and remaining-byte tracker with a registered last-byte flag.
module mem_xfer_counter
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic [ADDR_W-1:0] offset_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] offset_q;
    logic [ADDR_W-1:0] remain_q;
    logic              last_q;

    // Load restarts the walk at offset 0; each step advances one byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            offset_q <= '0;
            remain_q <= '0;
            last_q   <= 1'b0;
        end else if (load_i) begin
            offset_q <= '0;
            remain_q <= len_i;
            last_q   <= (len_i == ADDR_W'(1));
        end else if (step_i) begin
            offset_q <= ADDR_W'(offset_q + ADDR_W'(1));
            remain_q <= ADDR_W'(remain_q - ADDR_W'(1));
            last_q   <= (remain_q == ADDR_W'(2));
        end
    end

    assign offset_o = offset_q;
    assign last_o   = last_q;

endmodule

// File: rtl/mem_initiator.sv
// Memory initiator: single-byte load/store and forward byte-wise block copy.
module mem_initiator
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] input_addr,
    output logic [DATA_W-1:0] dataMemWrite,
    input  logic [DATA_W-1:0] readData
);

    state_e            state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdat_q;

    logic              cnt_load_c;
    logic              cnt_step_c;
    logic [ADDR_W-1:0] offset;
    logic              last;

    // Counter control: load on an accepted non-empty copy, step after each copy write.
    always_comb begin
        cnt_load_c = 1'b0;
        cnt_step_c = 1'b0;
        if (state_q == S_IDLE && req && op_e'(op) == OP_COPY && len != '0) begin
            cnt_load_c = 1'b1;
        end
        if (state_q == S_CP_WR) begin
            cnt_step_c = 1'b1;
        end
    end

    mem_xfer_counter u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load_i   (cnt_load_c),
        .step_i   (cnt_step_c),
        .len_i    (len),
        .offset_o (offset),
        .last_o   (last)
    );

    // Sequencer; every output is set on the edge that enters the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdat_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        src_q  <= addr;
                        dst_q  <= dst;
                        busy_q <= 1'b1;
                        case (op_e'(op))
                            OP_LOAD: begin
                                state_q    <= S_RD;
                                mem_read_q <= 1'b1;
                                addr_q     <= addr;
                            end
                            OP_STORE: begin
                                state_q     <= S_WR;
                                mem_write_q <= 1'b1;
                                addr_q      <= addr;
                                wdat_q      <= wdata;
                            end
                            OP_COPY: begin
                                if (len == '0) begin
                                    state_q <= S_FIN;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q    <= S_CP_RD;
                                    mem_read_q <= 1'b1;
                                    addr_q     <= addr;
                                end
                            end
                            default: begin
                                state_q <= S_FIN;
                                done_q  <= 1'b1;
                                err_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RD: begin
                    rdata_q    <= readData;
                    mem_read_q <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= S_FIN;
                end
                S_WR: begin
                    mem_write_q <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= S_FIN;
                end
                S_CP_RD: begin
                    // The write-data register doubles as the latched copy byte.
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b1;
                    addr_q      <= ADDR_W'(dst_q + offset);
                    wdat_q      <= readData;
                    state_q     <= S_CP_WR;
                end
                S_CP_WR: begin
                    mem_write_q <= 1'b0;
                    if (last) begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        mem_read_q <= 1'b1;
                        addr_q     <= ADDR_W'(src_q + offset + ADDR_W'(1));
                        state_q    <= S_CP_RD;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign rdata        = rdata_q;
    assign memRead      = mem_read_q;
    assign memWrite     = mem_write_q;
    assign input_addr   = addr_q;
    assign dataMemWrite = wdat_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a 256-byte behavioural memory.
module tb_mem_initiator;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] dst;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rdata;
    logic       memRead;
    logic       memWrite;
    logic [7:0] input_addr;
    logic [7:0] dataMemWrite;
    logic [7:0] readData;

    logic [7:0] mem [256];
    logic       pl_we  = 1'b0;
    logic       mem_clr = 1'b0;
    logic [7:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mem_initiator dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .op           (op),
        .addr         (addr),
        .wdata        (wdata),
        .dst          (dst),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .input_addr   (input_addr),
        .dataMemWrite (dataMemWrite),
        .readData     (readData)
    );

    assign readData = mem[input_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (memWrite) begin
            mem[input_addr] <= dataMemWrite;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read and write strobes must never overlap.
    always @(negedge clk) begin
        chk("rd_wr_mutex", 32'(memRead & memWrite), 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    // Present a request for one edge; returns in cycle 1 after acceptance.
    task automatic accept(input logic [1:0] o, input logic [7:0] a, input logic [7:0] w,
                          input logic [7:0] d, input logic [7:0] l);
        req = 1'b1; op = o; addr = a; wdata = w; dst = d; len = l;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    logic [7:0] cp_src [4];

    initial begin
        cp_src[0] = 8'h11; cp_src[1] = 8'h22; cp_src[2] = 8'h33; cp_src[3] = 8'h44;
        reset = 1'b1; req = 1'b0; op = 2'b00; addr = '0; wdata = '0; dst = '0; len = '0;
        mem_clr = 1'b1;
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_strobes", 32'({memRead, memWrite}), 0);
        chk("rst_addr", 32'(input_addr), 0);
        chk("rst_wdat", 32'(dataMemWrite), 0);
        chk("rst_rdata", 32'(rdata), 0);
        mem_clr = 1'b0;
        reset = 1'b0;
        tick();

        // Store 0x5A to 0x10
        accept(2'b01, 8'h10, 8'h5A, 8'h00, 8'h00);
        chk("st_c1_wr", 32'({memRead, memWrite}), 32'b01);
        chk("st_c1_addr", 32'(input_addr), 32'h10);
        chk("st_c1_data", 32'(dataMemWrite), 32'h5A);
        chk("st_c1_busy", 32'({busy, done}), 32'b10);
        tick();
        chk("st_c2_done", 32'({busy, done, memWrite}), 32'b110);
        tick();
        chk("st_c3_idle", 32'({busy, done}), 32'b00);
        chk("st_mem", 32'(mem[8'h10]), 32'h5A);

        // Load from 0x10
        accept(2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
        chk("ld_c1_rd", 32'({memRead, memWrite}), 32'b10);
        chk("ld_c1_addr", 32'(input_addr), 32'h10);
        chk("ld_c1_done", 32'(done), 0);
        tick();
        chk("ld_c2_done", 32'({done, err, memRead}), 32'b100);
        chk("ld_rdata", 32'(rdata), 32'h5A);
        tick();

        // Wrapping copy 0xFE -> 0x20, 4 bytes
        for (int i = 0; i < 4; i++) poke(8'(8'hFE + i), cp_src[i]);
        accept(2'b10, 8'hFE, 8'h00, 8'h20, 8'd4);
        for (int i = 0; i < 4; i++) begin
            chk("cp_rd_strobe", 32'({memRead, memWrite, done}), 32'b100);
            chk("cp_rd_addr", 32'(input_addr), 32'(8'(8'hFE + i)));
            tick();
            chk("cp_wr_strobe", 32'({memRead, memWrite, done}), 32'b010);
            chk("cp_wr_addr", 32'(input_addr), 32'(8'h20 + i));
            chk("cp_wr_data", 32'(dataMemWrite), 32'(cp_src[i]));
            tick();
        end
        chk("cp_c9_done", 32'({done, err, memRead, memWrite}), 32'b1000);
        chk("cp_rdata_kept", 32'(rdata), 32'h5A);
        tick();
        chk("cp_idle", 32'(busy), 0);
        for (int i = 0; i < 4; i++) chk("cp_mem", 32'(mem[8'h20 + i]), 32'(cp_src[i]));

        // Zero-length copy
        accept(2'b10, 8'h30, 8'h00, 8'h40, 8'd0);
        chk("cp0_c1", 32'({busy, done, err, memRead, memWrite}), 32'b11000);
        tick();
        chk("cp0_c2", 32'({busy, done}), 32'b00);

        // Reserved opcode
        accept(2'b11, 8'h55, 8'h66, 8'h77, 8'd9);
        chk("rsv_c1", 32'({busy, done, err, memRead, memWrite}), 32'b11100);
        chk("rsv_rdata", 32'(rdata), 32'h5A);
        tick();
        chk("rsv_c2", 32'({busy, done, err}), 32'b000);

        // Overlapping forward copy 0x40 -> 0x41, 3 bytes replicates the first byte
        poke(8'h40, 8'hA1); poke(8'h41, 8'hB2); poke(8'h42, 8'hC3);
        accept(2'b10, 8'h40, 8'h00, 8'h41, 8'd3);
        wait_done("ovl_timeout", 20);
        tick();
        chk("ovl_41", 32'(mem[8'h41]), 32'hA1);
        chk("ovl_42", 32'(mem[8'h42]), 32'hA1);
        chk("ovl_43", 32'(mem[8'h43]), 32'hA1);

        // Request while busy is ignored
        poke(8'h80, 8'h7E); poke(8'h81, 8'h7F);
        accept(2'b10, 8'h80, 8'h00, 8'h90, 8'd2);
        tick();
        req = 1'b1; op = 2'b11;
        tick();
        req = 1'b0;
        tick(); tick();
        chk("ign_done", 32'({done, err}), 32'b10);
        tick();
        chk("ign_idle", 32'({busy, done, err}), 32'b000);
        chk("ign_mem", 32'({mem[8'h90], mem[8'h91]}), 32'h7E7F);

        // Reset during CP_WR of byte 2 of a 5-byte copy
        for (int i = 0; i < 5; i++) poke(8'(8'h60 + i), 8'(i + 1));
        accept(2'b10, 8'h60, 8'h00, 8'h70, 8'd5);
        for (int i = 0; i < 5; i++) tick();
        chk("rab_at_wr2", 32'({memWrite, input_addr}), 32'h172);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rab_outs", 32'({busy, done, err, memRead, memWrite}), 0);
        chk("rab_addr_data", 32'({input_addr, dataMemWrite}), 0);
        chk("rab_rdata", 32'(rdata), 0);
        for (int i = 0; i < 3; i++) begin
            chk("rab_no_done", 32'({busy, done}), 0);
            tick();
        end
        chk("rab_mem01", 32'({mem[8'h70], mem[8'h71]}), 32'h0102);
        chk("rab_mem34", 32'({mem[8'h73], mem[8'h74]}), 32'h0000);

        // Reset wins over a simultaneous request
        reset = 1'b1; req = 1'b1; op = 2'b01; addr = 8'hAA; wdata = 8'hBB;
        tick();
        reset = 1'b0; req = 1'b0;
        chk("rst_prio", 32'({busy, memWrite}), 0);
        tick();
        chk("rst_prio_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port req, input, 1, request strobe; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2, opcode: 00 load, 01 store, 10 block copy, 11 reserved.
REQ-005 SHALL have port addr, input, 8, load/store address; copy source base.
REQ-006 SHALL have port wdata, input, 8, store data.
REQ-007 SHALL have port dst, input, 8, copy destination base.
REQ-008 SHALL have port len, input, 8, copy byte count (0..255).
REQ-009 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1, one-cycle pulse coincident with done on reserved op.
REQ-012 SHALL have port rdata, output, 8, last loaded byte; held until next load.
REQ-013 SHALL have port memRead, output, 1, memory read strobe.
REQ-014 SHALL have port memWrite, output, 1, memory write strobe.
REQ-015 SHALL have port input_addr, output, 8, memory address.
REQ-016 SHALL have port dataMemWrite, output, 8, memory write data.
REQ-017 SHALL have port readData, input, 8, memory read data, combinational from input_addr.

Function
REQ-018 SHALL implement states IDLE, RD, WR, CP_RD, CP_WR, FIN; all outputs registered.
REQ-019 SHALL latch op, addr, wdata, dst, len when req=1 in IDLE; req while busy SHALL be ignored.
REQ-020 Load: accepted cycle 0 -> cycle 1 RD (memRead=1, input_addr=addr) -> readData captured into rdata at end of cycle 1 -> cycle 2 FIN (done=1, rdata valid).
REQ-021 Store: cycle 1 WR (memWrite=1, input_addr=addr, dataMemWrite=wdata) -> cycle 2 FIN (done=1).
REQ-022 Copy, byte i=0..len-1: CP_RD (memRead, input_addr=addr+i, byte latched) then CP_WR (memWrite, input_addr=dst+i, dataMemWrite=latched byte); 2*len access cycles, then FIN.
REQ-023 Copy with len=0 SHALL go directly to FIN with no memRead/memWrite.
REQ-024 Address arithmetic SHALL be 8-bit modulo 256 (0xFF+1 wraps to 0x00).
REQ-025 Copy SHALL be strictly forward and byte-sequential; overlapping ranges SHALL see earlier written bytes (no memmove semantics).
REQ-026 Reserved op SHALL go to FIN with done=1, err=1, no memory access.
REQ-027 memRead and memWrite SHALL never be high in the same cycle; both 0 in IDLE and FIN.
REQ-028 FIN SHALL last exactly one cycle and return to IDLE; new req accepted in the following IDLE cycle.
REQ-029 rdata SHALL update only on load; copies SHALL not alter rdata.

Reset
REQ-030 On reset=1 at a rising edge: state IDLE; busy, done, err, memRead, memWrite = 0; input_addr, dataMemWrite, rdata = 0x00.
REQ-031 Reset mid-operation SHALL abort with no done pulse; partially copied bytes remain in memory.
REQ-032 Reset SHALL take priority over req in the same cycle.

Structure
REQ-033 Opcode constants and state encoding SHALL reside in shared package mem_pkg.
REQ-034 Copy offset and remaining-count tracking SHALL be a sub-module mem_xfer_counter (load, step, last flag).

Verification
REQ-035 Store 0x5A to 0x10, then load 0x10 -> memWrite one cycle at 0x10; done 2 cycles after each accept; rdata=0x5A.
REQ-036 Copy addr=0xFE, dst=0x20, len=4 -> reads 0xFE,0xFF,0x00,0x01; writes 0x20..0x23; done at cycle 9.
REQ-037 Copy len=0 -> no memory strobes; done at cycle 1 after accept.
REQ-038 op=11 -> done and err together one cycle; no strobes; rdata unchanged.
REQ-039 Reset asserted during CP_WR of byte 2 of len=5 copy -> next cycle IDLE, all outputs zero, no done; bytes 0-1 written.
REQ-040 req pulsed while busy -> ignored; memRead&memWrite never both 1 (assertion throughout).
